systolic_drain: RTL and testbench

- Output-side collector for the 32x32 systolic array.
- Sequences `matrix_index` to read one finished result matrix out of the array's skewed anti-diagonal output bus (`mul_outcome`).
- De-skews the anti-diagonals into row order and requantizes each 21-bit signed accumulation to 8 bits.
- Writes the matrix to the output SRAM as ARRAY_SIZE row words.

---
 rtl/systolic_drain.sv | 140 ++++++++++++++
 tb/tb_systolic_drain.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// Output-side collector for the 32x32 systolic array: walks the anti-diagonal bus,
// de-skews into rows, requantizes each 21-bit accumulation to 8 bits and writes 32 row words.
module systolic_drain #(
    parameter int ARRAY_SIZE    = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int OUTCOME_WIDTH = 21,
    parameter int ADDR_WIDTH    = 10,
    parameter int QUANT_SHIFT   = 7
) (
    input  logic                             i_clk,
    input  logic                             i_srst,
    input  logic                             i_drain_start,
    input  logic                             i_half_sel,
    input  logic [ADDR_WIDTH-1:0]            i_waddr_base,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] i_mul_outcome,
    output logic [5:0]                       o_matrix_index,
    output logic                             o_sram_wen,
    output logic [ADDR_WIDTH-1:0]            o_sram_waddr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_sram_wdata,
    output logic                             o_busy,
    output logic                             o_done
);

    // state     | meaning
    // S_IDLE    | waiting for drain_start
    // S_CAPTURE | step s: index={half,s}, quantize lanes into the de-skew buffer
    // S_WRITE   | step r: one buffered row word per cycle to the SRAM
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE} state_t;

    localparam int SW = $clog2(ARRAY_SIZE);
    localparam logic [SW-1:0] LAST = SW'(ARRAY_SIZE - 1);
    localparam logic signed [OUTCOME_WIDTH:0] RND  = (OUTCOME_WIDTH+1)'(1) << (QUANT_SHIFT - 1);
    localparam logic signed [OUTCOME_WIDTH:0] QMAX = (OUTCOME_WIDTH+1)'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [OUTCOME_WIDTH:0] QMIN = ~QMAX;

    state_t                   r_state;
    logic [SW-1:0]            r_step;
    logic                     r_half;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [DATA_WIDTH-1:0]    r_buf [ARRAY_SIZE][ARRAY_SIZE];

    logic [DATA_WIDTH-1:0]    w_q [ARRAY_SIZE];
    logic [SW-1:0]            w_row_sel;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row_word;

    // Sign-extend by one guard bit so the rounding add cannot overflow.
    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [OUTCOME_WIDTH-1:0] x);
        logic signed [OUTCOME_WIDTH:0] ext;
        logic signed [OUTCOME_WIDTH:0] y;
        ext = signed'({x[OUTCOME_WIDTH-1], x});
        y   = (ext + RND) >>> QUANT_SHIFT;
        if (y > QMAX)
            quantize = QMAX[DATA_WIDTH-1:0];
        else if (y < QMIN)
            quantize = QMIN[DATA_WIDTH-1:0];
        else
            quantize = y[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++)
            w_q[i] = quantize(i_mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]);
    end

    assign w_row_sel = (r_state == S_WRITE) ? r_step + SW'(1) : '0;

    // Row 0 leaves on the last capture edge, so its final column comes straight from lane 0.
    always_comb begin
        w_row_word = '0;
        for (int c = 0; c < ARRAY_SIZE; c++)
            w_row_word[(ARRAY_SIZE-1-c)*DATA_WIDTH +: DATA_WIDTH] = r_buf[w_row_sel][c];
        if (r_state == S_CAPTURE)
            w_row_word[DATA_WIDTH-1:0] = w_q[0];
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_CAPTURE) begin
            for (int i = 0; i < ARRAY_SIZE; i++)
                r_buf[i][r_step - SW'(i)] <= w_q[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state        <= S_IDLE;
            r_step         <= '0;
            r_half         <= 1'b0;
            r_base         <= '0;
            o_matrix_index <= '0;
            o_sram_wen     <= 1'b0;
            o_sram_waddr   <= '0;
            o_sram_wdata   <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_sram_wen <= 1'b0;
                    o_done     <= 1'b0;
                    if (i_drain_start) begin
                        r_half         <= i_half_sel;
                        r_base         <= i_waddr_base;
                        r_step         <= '0;
                        o_matrix_index <= {i_half_sel, 5'd0};
                        o_busy         <= 1'b1;
                        r_state        <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (r_step == LAST) begin
                        r_state      <= S_WRITE;
                        r_step       <= '0;
                        o_sram_wen   <= 1'b1;
                        o_sram_waddr <= r_base;
                        o_sram_wdata <= w_row_word;
                    end else begin
                        r_step         <= r_step + SW'(1);
                        o_matrix_index <= {r_half, r_step + SW'(1)};
                    end
                end
                S_WRITE: begin
                    if (r_step == LAST) begin
                        r_state    <= S_IDLE;
                        r_step     <= '0;
                        o_sram_wen <= 1'b0;
                        o_done     <= 1'b0;
                        o_busy     <= 1'b0;
                    end else begin
                        r_step       <= r_step + SW'(1);
                        o_sram_waddr <= o_sram_waddr + ADDR_WIDTH'(1);
                        o_sram_wdata <= w_row_word;
                        o_done       <= (r_step == LAST - SW'(1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: a golden matrix drives the skewed diagonal bus,
// expected row writes are queued at stimulus time and popped by a write monitor.
module tb_systolic_drain;

    logic         clk;
    logic         srst;
    logic         drain_start;
    logic         half_sel;
    logic [9:0]   waddr_base;
    logic [671:0] mul_outcome;
    logic [5:0]   matrix_index;
    logic         sram_wen;
    logic [9:0]   sram_waddr;
    logic [255:0] sram_wdata;
    logic         busy;
    logic         done;

    systolic_drain dut (
        .i_clk         (clk),
        .i_srst        (srst),
        .i_drain_start (drain_start),
        .i_half_sel    (half_sel),
        .i_waddr_base  (waddr_base),
        .i_mul_outcome (mul_outcome),
        .o_matrix_index(matrix_index),
        .o_sram_wen    (sram_wen),
        .o_sram_waddr  (sram_waddr),
        .o_sram_wdata  (sram_wdata),
        .o_busy        (busy),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]   addr;
        logic [255:0] data;
        logic         last;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [20:0] gold  [32][32];
    logic [7:0]  exp_b [32][32];
    int sat_in  [6] = '{64, 63, -64, -65, 1048575, -1048576};
    int sat_out [6] = '{1, 0, 0, -1, 127, -128};

    // Array model: lane i on diagonal s carries C[i][(s-i) mod 32] for either half.
    always_comb begin
        mul_outcome = '0;
        for (int i = 0; i < 32; i++)
            mul_outcome[i*21 +: 21] = gold[i][5'(matrix_index[4:0] - 5'(i))];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sram_wen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %0d with nothing expected at %0t", sram_waddr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("waddr", 64'(sram_waddr), 64'(mon_e.addr));
                chk("done_with_write", 64'(done), 64'(mon_e.last));
                n_checks++;
                if (sram_wdata !== mon_e.data) begin
                    n_errors++;
                    $display("FAIL wdata addr %0d: got %h expected %h", sram_waddr, sram_wdata, mon_e.data);
                end
            end
        end else if (done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_without_write at %0t", $time);
        end
    end

    task automatic set_ramp();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                gold[r][c]  = 21'((r + c - 31) * 128);
                exp_b[r][c] = 8'(r + c - 31);
            end
    endtask

    task automatic set_sat();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                gold[r][c]  = 21'(sat_in[r % 6]);
                exp_b[r][c] = 8'(sat_out[r % 6]);
            end
    endtask

    task automatic push_rows(input logic [9:0] b, input int nrows);
        wr_t w;
        for (int r = 0; r < nrows; r++) begin
            w.addr = b + 10'(r);
            for (int c = 0; c < 32; c++)
                w.data[(31-c)*8 +: 8] = exp_b[r][c];
            w.last = (r == 31);
            exp_q.push_back(w);
        end
    endtask

    // Called at a negedge; pulses drain_start there and follows the drain cycle by cycle.
    task automatic run_drain(input logic h, input logic [9:0] b, input int re1, input int re2,
                             input int rst_at);
        int nrows;
        if (rst_at == 0)       nrows = 32;
        else if (rst_at >= 33) nrows = rst_at - 32;
        else                   nrows = 0;
        push_rows(b, nrows);
        drain_start = 1'b1;
        half_sel    = h;
        waddr_base  = b;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            drain_start = 1'b0;
            if (rst_at != 0 && k == rst_at + 1) begin
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_wen", 64'(sram_wen), 64'd0);
                chk("rst_index", 64'(matrix_index), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                srst = 1'b0;
                break;
            end
            if (k <= 64) begin
                chk("busy_high", 64'(busy), 64'd1);
                chk("index", 64'(matrix_index),
                    (k <= 32) ? 64'({h, 5'(k - 1)}) : 64'({h, 5'd31}));
            end else begin
                chk("busy_low_after", 64'(busy), 64'd0);
                chk("wen_low_after", 64'(sram_wen), 64'd0);
            end
            if (k == re1 || k == re2) begin
                drain_start = 1'b1;
                half_sel    = ~h;
                waddr_base  = b + 10'd77;
            end
            if (k == rst_at) srst = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        srst        = 1'b1;
        drain_start = 1'b0;
        half_sel    = 1'b0;
        waddr_base  = '0;
        set_ramp();
        repeat (3) @(negedge clk);
        chk("reset_index", 64'(matrix_index), 64'd0);
        chk("reset_wen", 64'(sram_wen), 64'd0);
        chk("reset_waddr", 64'(sram_waddr), 64'd0);
        chk("reset_wdata_zero", 64'(sram_wdata != '0), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        srst = 1'b0;
        idle(2);

        run_drain(1'b0, 10'd0, 0, 0, 0);
        set_sat();
        run_drain(1'b0, 10'd100, 0, 0, 0);
        set_ramp();
        run_drain(1'b1, 10'd1020, 0, 0, 0);

        run_drain(1'b0, 10'd500, 10, 40, 0);
        run_drain(1'b1, 10'd600, 0, 0, 0);

        run_drain(1'b0, 10'd200, 0, 0, 20);
        idle(5);
        set_sat();
        run_drain(1'b1, 10'd300, 0, 0, 45);
        idle(5);
        set_ramp();
        run_drain(1'b1, 10'd5, 0, 0, 0);

        drain_start = 1'b1;
        srst        = 1'b1;
        half_sel    = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        srst        = 1'b0;
        chk("coinc_index", 64'(matrix_index), 64'd0);
        chk("coinc_wen", 64'(sram_wen), 64'd0);
        idle(40);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
